acc_rsp_collector: RTL and testbench

ACC_RSP_COLLECTOR -- requirements
Module: acc_rsp_collector

---
 rtl/acc_rsp_collector.sv | 218 +++++++++++++++++++++
 tb/tb_acc_rsp_collector.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_rsp_collector.sv
// -----------------------------------------------------------------------------
// acc_rsp_collector
//
// Collects accelerator responses coming back from the interconnect and hands
// them to the core in arrival order. Responses are buffered in a small FIFO.
// A counter tracks how many issued requests are still waiting for their
// writeback. A response that arrives when nothing is pending is dropped and
// flagged for one cycle.
//
// Parameters
//   DataWidth      : width of response data
//   Depth          : response buffer entries (power of two, >= 2)
//   MaxOutstanding : maximum issued-but-undelivered requests
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous reset, ACTIVE-HIGH (name kept from the
//                    existing codebase)
//   issue_valid_i  : one request issued this cycle that expects a writeback
//   issue_stall_o  : outstanding limit reached; issues are not counted
//   c_rsp_valid_i  : interconnect response valid
//   c_rsp_ready_o  : collector can take a response
//   c_rsp_data_i   : response data
//   c_rsp_rd_i     : destination register index
//   c_rsp_error_i  : accelerator error flag (forwarded only)
//   x_rsp_valid_o  : response to core valid
//   x_rsp_ready_i  : core accepts response
//   x_rsp_data_o   : head entry data
//   x_rsp_rd_o     : head entry register index
//   x_rsp_error_o  : head entry error flag
//   outstanding_o  : issued-but-undelivered count
//   spurious_o     : one-cycle pulse, a response was dropped (nothing pending)
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds valid and payload stable
// until the transfer; ready never depends combinationally on valid.
// c_rsp_ready_o depends only on the buffer fill level (no pop-to-push path),
// x_rsp_valid_o depends only on the buffer fill level (no bypass).
// -----------------------------------------------------------------------------
module acc_rsp_collector #(
    parameter int DataWidth      = 32,
    parameter int Depth          = 4,
    parameter int MaxOutstanding = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,

    input  logic                                   issue_valid_i,
    output logic                                   issue_stall_o,

    input  logic                                   c_rsp_valid_i,
    output logic                                   c_rsp_ready_o,
    input  logic [DataWidth-1:0]                   c_rsp_data_i,
    input  logic [4:0]                             c_rsp_rd_i,
    input  logic                                   c_rsp_error_i,

    output logic                                   x_rsp_valid_o,
    input  logic                                   x_rsp_ready_i,
    output logic [DataWidth-1:0]                   x_rsp_data_o,
    output logic [4:0]                             x_rsp_rd_o,
    output logic                                   x_rsp_error_o,

    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
    output logic                                   spurious_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);
    localparam int OutW = $clog2(MaxOutstanding + 1);
    // Common width for the pending computation; Depth may exceed
    // MaxOutstanding or vice versa.
    localparam int CmpW = (OutW > CntW) ? OutW : CntW;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [4:0]           rd;
        logic                 error;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    entry_t          mem_q [Depth];
    entry_t          mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [OutW-1:0] outstanding_q, outstanding_d;
    logic            spurious_q, spurious_d;

    // -------------------------------------------------------------------------
    // Handshake and event decode
    // -------------------------------------------------------------------------
    logic            buf_full;
    logic            buf_empty;
    logic            in_hs;
    logic            out_hs;
    logic            issue_acc;
    logic            push;
    logic            pop;
    logic [CmpW-1:0] pending;
    logic            none_pending;
    entry_t          in_entry;
    entry_t          head_entry;

    assign buf_full  = (count_q == CntW'(Depth));
    assign buf_empty = (count_q == '0);

    assign c_rsp_ready_o = ~buf_full;
    assign x_rsp_valid_o = ~buf_empty;
    assign issue_stall_o = (outstanding_q == OutW'(MaxOutstanding));

    assign in_hs     = c_rsp_valid_i & c_rsp_ready_o;
    assign out_hs    = x_rsp_valid_o & x_rsp_ready_i;
    assign issue_acc = issue_valid_i & ~issue_stall_o;

    // Requests issued but whose response has not yet entered the buffer.
    // count never exceeds outstanding, so this never wraps.
    assign pending      = CmpW'(outstanding_q) - CmpW'(count_q);
    assign none_pending = (pending == '0);

    // A same-cycle issue does not make a response legitimate: pending is
    // evaluated on the registered counter only.
    assign push = in_hs & ~none_pending;
    assign pop  = out_hs;

    assign in_entry.data  = c_rsp_data_i;
    assign in_entry.rd    = c_rsp_rd_i;
    assign in_entry.error = c_rsp_error_i;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Depth is a power of two, so natural pointer overflow wraps modulo Depth.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        // A pop implies count >= 1 and so outstanding >= 1; an accepted issue
        // implies outstanding < MaxOutstanding. Neither direction can wrap.
        unique case ({issue_acc, pop})
            2'b10:   outstanding_d = outstanding_q + OutW'(1);
            2'b01:   outstanding_d = outstanding_q - OutW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        spurious_d = in_hs & none_pending;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            spurious_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            spurious_q    <= spurious_d;
        end
    end

    // Buffer storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Head entry only changes on a pop, so fields stay stable while the core
    // back-pressures.
    assign head_entry    = mem_q[rd_ptr_q];
    assign x_rsp_data_o  = head_entry.data;
    assign x_rsp_rd_o    = head_entry.rd;
    assign x_rsp_error_o = head_entry.error;

    assign outstanding_o = outstanding_q;
    assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_acc_rsp_collector.sv
module tb_acc_rsp_collector;

  localparam int DW = 32;
  localparam int EW = DW + 6;
  localparam int OW = 4;

  logic          clk;
  logic          rst_n;
  logic          issue_valid_i;
  logic          issue_stall_o;
  logic          c_rsp_valid_i;
  logic          c_rsp_ready_o;
  logic [DW-1:0] c_rsp_data_i;
  logic [4:0]    c_rsp_rd_i;
  logic          c_rsp_error_i;
  logic          x_rsp_valid_o;
  logic          x_rsp_ready_i;
  logic [DW-1:0] x_rsp_data_o;
  logic [4:0]    x_rsp_rd_o;
  logic          x_rsp_error_o;
  logic [OW-1:0] outstanding_o;
  logic          spurious_o;

  logic [EW-1:0] exp_q[$];
  int            n_cmp;
  int            n_err;

  acc_rsp_collector #(
    .DataWidth(DW),
    .Depth(4),
    .MaxOutstanding(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .issue_valid_i(issue_valid_i),
    .issue_stall_o(issue_stall_o),
    .c_rsp_valid_i(c_rsp_valid_i),
    .c_rsp_ready_o(c_rsp_ready_o),
    .c_rsp_data_i(c_rsp_data_i),
    .c_rsp_rd_i(c_rsp_rd_i),
    .c_rsp_error_i(c_rsp_error_i),
    .x_rsp_valid_o(x_rsp_valid_o),
    .x_rsp_ready_i(x_rsp_ready_i),
    .x_rsp_data_o(x_rsp_data_o),
    .x_rsp_rd_o(x_rsp_rd_o),
    .x_rsp_error_o(x_rsp_error_o),
    .outstanding_o(outstanding_o),
    .spurious_o(spurious_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_issue(input int n);
    for (int i = 0; i < n; i++) begin
      issue_valid_i = 1'b1;
      tick();
    end
    issue_valid_i = 1'b0;
  endtask

  // Drives one response until accepted; queues it as expected output unless
  // it is expected to be dropped as spurious.
  task automatic send_rsp(input logic [DW-1:0] d, input logic [4:0] rd, input logic err,
                          input logic spur);
    logic done;
    done          = 1'b0;
    c_rsp_valid_i = 1'b1;
    c_rsp_data_i  = d;
    c_rsp_rd_i    = rd;
    c_rsp_error_i = err;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (c_rsp_ready_o) begin
        if (!spur) exp_q.push_back({err, rd, d});
        done = 1'b1;
        break;
      end
    end
    tick();
    c_rsp_valid_i = 1'b0;
    check("send_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_empty();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    tick();
    check("drain_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x_valid"}, {63'd0, x_rsp_valid_o}, 64'd0);
    check({tag, "_c_ready"}, {63'd0, c_rsp_ready_o}, 64'd1);
    check({tag, "_stall"}, {63'd0, issue_stall_o}, 64'd0);
    check({tag, "_spurious"}, {63'd0, spurious_o}, 64'd0);
    check({tag, "_outstanding"}, {60'd0, outstanding_o}, 64'd0);
  endtask

  task automatic single_txn(input string tag);
    x_rsp_ready_i = 1'b1;
    do_issue(1);
    check({tag, "_out_a"}, {60'd0, outstanding_o}, 64'd1);
    send_rsp(32'hDEADBEEF, 5'd5, 1'b0, 1'b0);
    check({tag, "_out_b"}, {60'd0, outstanding_o}, 64'd1);
    check({tag, "_x_valid"}, {63'd0, x_rsp_valid_o}, 64'd1);
    tick();
    check({tag, "_out_c"}, {60'd0, outstanding_o}, 64'd0);
    check({tag, "_x_idle"}, {63'd0, x_rsp_valid_o}, 64'd0);
  endtask

  // scoreboard: compares head fields at each delivery and while held back
  always @(negedge clk) begin
    if (!rst_n && x_rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {63'd0, x_rsp_valid_o}, 64'd0);
      end else if (x_rsp_ready_i) begin
        check("rsp", {26'd0, x_rsp_error_o, x_rsp_rd_o, x_rsp_data_o}, {26'd0, exp_q.pop_front()});
      end else begin
        check("rsp_hold", {26'd0, x_rsp_error_o, x_rsp_rd_o, x_rsp_data_o}, {26'd0, exp_q[0]});
      end
    end
  end

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b1;
    issue_valid_i = 1'b0;
    c_rsp_valid_i = 1'b0;
    c_rsp_data_i  = '0;
    c_rsp_rd_i    = '0;
    c_rsp_error_i = 1'b0;
    x_rsp_ready_i = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b0;
    tick();

    // single transaction
    single_txn("single");

    // fill the buffer with the core stalled
    x_rsp_ready_i = 1'b0;
    do_issue(6);
    check("fill_out6", {60'd0, outstanding_o}, 64'd6);
    send_rsp(32'h1111_0001, 5'd1, 1'b0, 1'b0);
    send_rsp(32'h2222_0002, 5'd2, 1'b1, 1'b0);
    send_rsp(32'h3333_0003, 5'd3, 1'b0, 1'b0);
    send_rsp(32'h4444_0004, 5'd4, 1'b1, 1'b0);
    check("fill_full_ready", {63'd0, c_rsp_ready_o}, 64'd0);
    c_rsp_valid_i = 1'b1;
    c_rsp_data_i  = 32'h5555_0005;
    c_rsp_rd_i    = 5'd6;
    c_rsp_error_i = 1'b0;
    tick();
    tick();
    check("fill_still_full", {63'd0, c_rsp_ready_o}, 64'd0);
    check("fill_out_held", {60'd0, outstanding_o}, 64'd6);
    x_rsp_ready_i = 1'b1;
    send_rsp(32'h5555_0005, 5'd6, 1'b0, 1'b0);
    wait_empty();
    check("fill_out1", {60'd0, outstanding_o}, 64'd1);
    send_rsp($urandom, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
    wait_empty();
    check("fill_out0", {60'd0, outstanding_o}, 64'd0);

    // spurious response
    send_rsp(32'h0000_1234, 5'd1, 1'b0, 1'b1);
    check("spur_pulse", {63'd0, spurious_o}, 64'd1);
    check("spur_no_valid", {63'd0, x_rsp_valid_o}, 64'd0);
    tick();
    check("spur_pulse_end", {63'd0, spurious_o}, 64'd0);
    check("spur_out", {60'd0, outstanding_o}, 64'd0);

    // outstanding limit
    x_rsp_ready_i = 1'b0;
    do_issue(9);
    check("limit_out", {60'd0, outstanding_o}, 64'd8);
    check("limit_stall", {63'd0, issue_stall_o}, 64'd1);
    send_rsp(32'hA5A5_0000, 5'd9, 1'b0, 1'b0);
    x_rsp_ready_i = 1'b1;
    tick();
    x_rsp_ready_i = 1'b0;
    check("limit_out7", {60'd0, outstanding_o}, 64'd7);
    check("limit_stall_drop", {63'd0, issue_stall_o}, 64'd0);
    x_rsp_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_rsp($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
    end
    wait_empty();
    check("limit_drained", {60'd0, outstanding_o}, 64'd0);

    // issue + pop + push in one cycle
    x_rsp_ready_i = 1'b0;
    do_issue(3);
    send_rsp(32'hAAAA_000A, 5'd10, 1'b0, 1'b0);
    issue_valid_i = 1'b1;
    x_rsp_ready_i = 1'b1;
    send_rsp(32'hBBBB_000B, 5'd11, 1'b1, 1'b0);
    issue_valid_i = 1'b0;
    x_rsp_ready_i = 1'b0;
    check("simul_out", {60'd0, outstanding_o}, 64'd3);
    check("simul_x_valid", {63'd0, x_rsp_valid_o}, 64'd1);
    check("simul_c_ready", {63'd0, c_rsp_ready_o}, 64'd1);
    tick();
    x_rsp_ready_i = 1'b1;
    wait_empty();
    check("simul_count0", {63'd0, x_rsp_valid_o}, 64'd0);
    check("simul_out2", {60'd0, outstanding_o}, 64'd2);

    // reset in the middle of traffic
    x_rsp_ready_i = 1'b0;
    do_issue(3);
    for (int i = 0; i < 3; i++) begin
      send_rsp($urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
    end
    check("mid_out5", {60'd0, outstanding_o}, 64'd5);
    check("mid_c_ready", {63'd0, c_rsp_ready_o}, 64'd1);
    #2;
    rst_n = 1'b1;
    #1;
    exp_q.delete();
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    single_txn("post_rst");

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
